// File: rtl/adc_read_pkg.sv
// Shared types and width helpers for the serial ADC read sequencer.
package adc_read_pkg;

    // Sequencer states; encoding is fixed so it can be observed on a debug bus.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_e;

    // Counter width for a count range of max_count values, never below one bit.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Default configuration and the counter widths it implies.
    localparam int DEF_DATA_WIDTH  = 24;
    localparam int DEF_NUM_CYCLES  = 25;
    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_CONV_CYCLES = 100;

    localparam int DEF_CONV_CNT_W   = cnt_width(DEF_CONV_CYCLES);
    localparam int DEF_DIV_CNT_W    = cnt_width(DEF_CLK_DIV);
    localparam int DEF_PERIOD_CNT_W = cnt_width(DEF_NUM_CYCLES + 1);

endpackage

// File: rtl/adc_dclk_gen.sv
// Serial clock divider: ClkDiv system cycles per half-period, low phase first.
// The strobes flag the system-clock edge on which dclk is about to toggle.
module adc_dclk_gen
    import adc_read_pkg::*;
#(
    parameter int ClkDiv = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable,
    output logic dclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DivW = cnt_width(ClkDiv);

    logic [DivW-1:0] div_cnt_r;
    logic            dclk_r;
    logic            phase_end_s;

    assign phase_end_s = (div_cnt_r == DivW'(ClkDiv - 1));
    assign dclk        = dclk_r;

    // Edge strobes: valid only while enabled, qualified by the current level.
    always_comb begin
        rise_stb = 1'b0;
        fall_stb = 1'b0;
        if (enable && phase_end_s) begin
            rise_stb = ~dclk_r;
            fall_stb = dclk_r;
        end else begin
            rise_stb = 1'b0;
            fall_stb = 1'b0;
        end
    end

    // Half-period counter and dclk level; disabling parks dclk low immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_r <= '0;
            dclk_r    <= 1'b0;
        end else if (!enable) begin
            div_cnt_r <= '0;
            dclk_r    <= 1'b0;
        end else if (phase_end_s) begin
            div_cnt_r <= '0;
            dclk_r    <= ~dclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DivW'(1);
        end
    end

endmodule

// File: rtl/adc_read_ctrl.sv
// Single-shot serial ADC read sequencer: conversion pulse, timed wait, then
// NumCycles dclk periods shifting sdo_i in MSB first; result strobed on valid_o.
module adc_read_ctrl
    import adc_read_pkg::*;
#(
    parameter int DataWidth  = DEF_DATA_WIDTH,
    parameter int NumCycles  = DEF_NUM_CYCLES,
    parameter int ClkDiv     = DEF_CLK_DIV,
    parameter int ConvCycles = DEF_CONV_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 sdo_i,
    output logic                 conv_o,
    output logic                 cs_no,
    output logic                 dclk_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    output logic                 busy_o
);

    localparam int ConvW = cnt_width(ConvCycles);
    localparam int PerW  = cnt_width(NumCycles + 1);

    adc_state_e           state_r;
    adc_state_e           state_nxt_s;
    logic [ConvW-1:0]     conv_cnt_r;
    logic [PerW-1:0]      period_cnt_r;
    logic [DataWidth-1:0] shift_r;
    logic [DataWidth-1:0] data_r;
    logic                 conv_r;
    logic                 cs_n_r;
    logic                 valid_r;
    logic                 busy_r;

    logic                 dclk_en_s;
    logic                 dclk_s;
    logic                 rise_stb_s;
    logic                 fall_stb_s;
    logic                 conv_done_s;
    logic                 shift_done_s;

    // Divider runs only in SHIFT; an abort stops it so dclk is low next cycle.
    assign dclk_en_s = (state_r == ST_SHIFT) && !abort_i;

    adc_dclk_gen #(
        .ClkDiv (ClkDiv)
    ) u_dclk_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable   (dclk_en_s),
        .dclk     (dclk_s),
        .rise_stb (rise_stb_s),
        .fall_stb (fall_stb_s)
    );

    assign conv_done_s  = (conv_cnt_r == ConvW'(ConvCycles - 1));
    // Read ends on the falling edge that closes the high phase of the last period.
    assign shift_done_s = fall_stb_s && (period_cnt_r == PerW'(NumCycles));

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        if (abort_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_nxt_s = ST_CONV;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CONV: begin
                    if (conv_done_s) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_CONV;
                    end
                end
                ST_SHIFT: begin
                    if (shift_done_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Conversion timer: counts while staying in CONV, cleared otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conv_cnt_r <= '0;
        end else if ((state_r == ST_CONV) && (state_nxt_s == ST_CONV)) begin
            conv_cnt_r <= conv_cnt_r + ConvW'(1);
        end else begin
            conv_cnt_r <= '0;
        end
    end

    // Period counter and shift register: advance on each dclk rise within SHIFT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_cnt_r <= '0;
            shift_r      <= '0;
        end else if ((state_r == ST_SHIFT) && (state_nxt_s == ST_SHIFT)) begin
            if (rise_stb_s) begin
                period_cnt_r <= period_cnt_r + PerW'(1);
                shift_r      <= {shift_r[DataWidth-2:0], sdo_i};
            end else begin
                period_cnt_r <= period_cnt_r;
                shift_r      <= shift_r;
            end
        end else begin
            period_cnt_r <= '0;
            shift_r      <= '0;
        end
    end

    // Pin and handshake registers, decoded from the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conv_r  <= 1'b0;
            cs_n_r  <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            data_r  <= '0;
        end else begin
            conv_r  <= (state_nxt_s == ST_CONV);
            cs_n_r  <= (state_nxt_s != ST_SHIFT);
            valid_r <= (state_nxt_s == ST_DONE);
            busy_r  <= (state_nxt_s == ST_CONV) || (state_nxt_s == ST_SHIFT);
            if (state_nxt_s == ST_DONE) begin
                data_r <= shift_r;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign conv_o  = conv_r;
    assign cs_no   = cs_n_r;
    assign dclk_o  = dclk_s;
    assign data_o  = data_r;
    assign valid_o = valid_r;
    assign busy_o  = busy_r;

endmodule
